// File: rtl/serial_detect_scheduler.sv
// Round-robin scheduler that lends a serial Mealy sequence detector to one of four
// requesters at a time, shifts that requester's frame through it and reports the hit count.
module serial_detect_scheduler #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] frame_data,
  input  logic        flush,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        det_y,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [3:0]  det_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 1);

  ctrl_t      state;
  det_t       det;
  det_t       det_next;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] acc;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [1:0] win_idx;
  logic       win_found;

  // First requester at or after ptr, wrapping 3->0.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!win_found && req[ptr + 2'(i)]) begin
        win_idx   = ptr + 2'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    det_next = S0;
    case (det)
      S0: det_next = shreg[0] ? S1 : S0;
      S1: det_next = shreg[0] ? S3 : S0;
      S3: det_next = shreg[0] ? S2 : S0;
      S2: det_next = shreg[0] ? S2 : S0;
      default: det_next = S0;
    endcase
  end

  assign det_y = (state == SHIFT) && (det != S0) && !shreg[0];
  assign busy  = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      det       <= S0;
      shreg     <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      det_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            owner     <= win_idx;
            grant     <= 4'b0001 << win_idx;
            shreg     <= frame_data[{win_idx, 3'b000} +: 8];
            det       <= S0;
            bit_cnt   <= '0;
            acc       <= '0;
            det_count <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (flush) begin
            state <= IDLE;
            grant <= '0;
            det   <= S0;
          end else begin
            shreg   <= shreg >> 1;
            det     <= det_next;
            acc     <= acc + {3'b000, det_y};
            bit_cnt <= bit_cnt + 3'd1;
            // Pointer advances only on completion so an aborted frame keeps its priority.
            if (bit_cnt == LAST_BIT) begin
              state     <= REPORT;
              grant     <= '0;
              done      <= 1'b1;
              done_id   <= owner;
              det_count <= acc + {3'b000, det_y};
              ptr       <= owner + 2'd1;
            end
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_detect_scheduler.sv
// Directed bench for serial_detect_scheduler: detection patterns, round-robin order,
// flush, mid-frame reset and frame latency, each with hand-computed expectations.
module tb_serial_detect_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] frame_data;
  logic        flush;
  logic [3:0]  grant;
  logic        busy;
  logic        det_y;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  det_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_detect_scheduler #(.FRAME_LEN(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .frame_data (frame_data),
    .flush      (flush),
    .grant      (grant),
    .busy       (busy),
    .det_y      (det_y),
    .done       (done),
    .done_id    (done_id),
    .det_count  (det_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; flush = 1'b1; frame_data = '1;
    tick(); tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (det_y !== 1'b0) begin bad++; $display("FAIL reset_det_y: got %b want 0", det_y); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (done_id !== 2'd0) begin bad++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    total++; if (det_count !== 4'd0) begin bad++; $display("FAIL reset_det_count: got %0d want 0", det_count); end
    reset = 1'b1; req = 4'b0000; flush = 1'b0;
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_grant: got %b want 0000", grant); end
  endtask

  // Frame 0 = 8'h06: bits LSB first 0,1,1,0,... -> single hit on bit 3.
  task automatic test_det_06();
    logic [7:0] exp_y;
    exp_y = 8'b0000_1000;
    frame_data = 32'h0000_0006; req = 4'b0001;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL f06_grant: got %b want 0001", grant); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL f06_busy: got %b want 1", busy); end
    req = 4'b0000; frame_data = '1;
    for (int b = 0; b < 8; b++) begin
      total++; if (det_y !== exp_y[b]) begin bad++; $display("FAIL f06_det_y bit %0d: got %b want %b", b, det_y, exp_y[b]); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL f06_early_done bit %0d: got %b want 0", b, done); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL f06_done: got %b want 1", done); end
    total++; if (done_id !== 2'd0) begin bad++; $display("FAIL f06_done_id: got %0d want 0", done_id); end
    total++; if (det_count !== 4'd1) begin bad++; $display("FAIL f06_det_count: got %0d want 1", det_count); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL f06_report_grant: got %b want 0000", grant); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL f06_report_busy: got %b want 1", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL f06_done_pulse: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL f06_idle_busy: got %b want 0", busy); end
    total++; if (det_count !== 4'd1) begin bad++; $display("FAIL f06_count_hold: got %0d want 1", det_count); end
  endtask

  // Frame 2 = 8'h55: alternating 1,0 -> hits on bits 1,3,5,7.
  task automatic test_det_55();
    logic [7:0] exp_y;
    exp_y = 8'b1010_1010;
    frame_data = 32'h0055_0000; req = 4'b0100;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL f55_grant: got %b want 0100", grant); end
    total++; if (det_count !== 4'd0) begin bad++; $display("FAIL f55_count_clear: got %0d want 0", det_count); end
    req = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      total++; if (det_y !== exp_y[b]) begin bad++; $display("FAIL f55_det_y bit %0d: got %b want %b", b, det_y, exp_y[b]); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL f55_done: got %b want 1", done); end
    total++; if (done_id !== 2'd2) begin bad++; $display("FAIL f55_done_id: got %0d want 2", done_id); end
    total++; if (det_count !== 4'd4) begin bad++; $display("FAIL f55_det_count: got %0d want 4", det_count); end
    tick();
  endtask

  // All-ones (requester 3) and all-zeros (requester 0) frames never hit.
  task automatic test_det_flat();
    logic [31:0] fd [2];
    logic [3:0]  rq [2];
    logic [1:0]  id [2];
    fd[0] = 32'hFF00_0000; rq[0] = 4'b1000; id[0] = 2'd3;
    fd[1] = 32'h0000_0000; rq[1] = 4'b0001; id[1] = 2'd0;
    for (int k = 0; k < 2; k++) begin
      frame_data = fd[k]; req = rq[k];
      tick();
      total++; if (grant !== rq[k]) begin bad++; $display("FAIL flat%0d_grant: got %b want %b", k, grant, rq[k]); end
      req = 4'b0000;
      for (int b = 0; b < 8; b++) begin
        total++; if (det_y !== 1'b0) begin bad++; $display("FAIL flat%0d_det_y bit %0d: got %b want 0", k, b, det_y); end
        tick();
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL flat%0d_done: got %b want 1", k, done); end
      total++; if (done_id !== id[k]) begin bad++; $display("FAIL flat%0d_done_id: got %0d want %0d", k, done_id, id[k]); end
      total++; if (det_count !== 4'd0) begin bad++; $display("FAIL flat%0d_det_count: got %0d want 0", k, det_count); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    int last_done;
    last_done = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 4'b1111; frame_data = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      total++; if (grant !== eg) begin bad++; $display("FAIL rr%0d_grant: got %b want %b", k, grant, eg); end
      for (int b = 0; b < 8; b++) tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rr%0d_done: got %b want 1", k, done); end
      total++; if (done_id !== 2'(k % 4)) begin bad++; $display("FAIL rr%0d_done_id: got %0d want %0d", k, done_id, k % 4); end
      if (k > 0) begin
        total++; if (cyc - last_done !== 10) begin bad++; $display("FAIL rr%0d_spacing: got %0d want 10", k, cyc - last_done); end
      end
      last_done = cyc;
      if (k == 4) req = 4'b0000;
      tick();
      total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr%0d_idle: got grant %b busy %b want 0000 0", k, grant, busy); end
      tick();
    end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rr_release: got %b want 0000", grant); end
  endtask

  task automatic test_flush();
    // Pointer is at 1 after the round-robin run.
    req = 4'b0110; frame_data = '0;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL flush_grant: got %b want 0010", grant); end
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL flush_grant_clear: got %b want 0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b want 0", done); end
    flush = 1'b0;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL flush_regrant: got %b want 0010", grant); end
    req = 4'b0000;
    for (int b = 0; b < 8; b++) tick();
    total++; if (done !== 1'b1 || done_id !== 2'd1) begin bad++; $display("FAIL flush_after_done: got %b id %0d want 1 id 1", done, done_id); end
    tick();
    // Flush while idle must not block the grant.
    flush = 1'b1; req = 4'b0001;
    tick();
    flush = 1'b0; req = 4'b0000;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL flush_idle_grant: got %b want 0001", grant); end
    for (int b = 0; b < 8; b++) tick();
    total++; if (done !== 1'b1 || done_id !== 2'd0) begin bad++; $display("FAIL flush_idle_done: got %b id %0d want 1 id 0", done, done_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_y;
    exp_y = 8'b0000_1000;
    frame_data = 32'h0000_0600; req = 4'b0100;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL rmid_grant: got %b want 0100", grant); end
    tick(); tick(); tick();
    reset = 1'b0; req = 4'b0010; flush = 1'b1;
    tick();
    total++; if ({grant, busy, det_y, done, done_id, det_count} !== 13'd0) begin bad++;
      $display("FAIL rmid_outputs: got grant %b busy %b y %b done %b id %0d cnt %0d want all 0", grant, busy, det_y, done, done_id, det_count); end
    tick();
    total++; if (done !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL rmid_hold: got done %b grant %b want 0 0000", done, grant); end
    reset = 1'b1; flush = 1'b0;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_regrant: got %b want 0010", grant); end
    req = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      total++; if (det_y !== exp_y[b]) begin bad++; $display("FAIL rmid_det_y bit %0d: got %b want %b", b, det_y, exp_y[b]); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b want 1", done); end
    total++; if (done_id !== 2'd1) begin bad++; $display("FAIL rmid_done_id: got %0d want 1", done_id); end
    total++; if (det_count !== 4'd1) begin bad++; $display("FAIL rmid_det_count: got %0d want 1", det_count); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done_pulse: got %b want 0", done); end
  endtask

  initial begin
    reset = 1'b0; req = '0; frame_data = '0; flush = 1'b0;
    test_reset();
    test_det_06();
    test_det_55();
    test_det_flat();
    test_round_robin();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
